regfile_wb_arbiter: RTL and testbench

//   Shares the single register-file write port among NREQ writeback requesters
//   (req0 = ALU, req1 = MULTDIV, req2 = LOAD). Uses round-robin arbitration with a

---
 rtl/regfile_pkg.sv | 18 +
 rtl/decoder_5_to_32bits.sv | 18 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/regfile_wb_arbiter.sv | 101 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_pkg                                                 |
// | Shared register-file geometry and writeback requester indices.       |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package regfile_pkg;

   localparam int REG_AW     = 5;
   localparam int REG_DW     = 32;
   localparam int NUM_REGS   = 32;

   localparam int WB_ALU     = 0;
   localparam int WB_MULTDIV = 1;
   localparam int WB_LOAD    = 2;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/decoder_5_to_32bits.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : decoder_5_to_32bits                                         |
// | Binary 5-bit index to 32-bit one-hot decoder.                        |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module decoder_5_to_32bits (
   input  logic [4:0]  i_sel,
   output logic [31:0] o_onehot
);

   always_comb begin
      o_onehot        = '0;
      o_onehot[i_sel] = 1'b1;
   end

endmodule : decoder_5_to_32bits
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rr_arbiter                                                  |
// | Combinational round-robin grant; search starts one past ptr.         |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_arbiter #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   int              w_idx;
   logic [IW-1:0]   w_sel;
   logic            w_found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      w_found   = 1'b0;
      w_idx     = 0;
      w_sel     = '0;
      for (int k = 1; k <= N; k++) begin
         w_idx = (int'(ptr) + k) % N;
         w_sel = IW'(w_idx);
         if (!w_found && req[w_sel]) begin
            w_found      = 1'b1;
            grant[w_sel] = 1'b1;
            grant_idx    = w_sel;
         end
      end
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : regfile_wb_arbiter                                          |
// | Round-robin share of the regfile write port with one register stage. |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int AW   = REG_AW,
   parameter int DW   = REG_DW
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 ctrl_writeEnable,
   output logic [AW-1:0]        ctrl_writeReg,
   output logic [DW-1:0]        data_writeReg,
   output logic [(2**AW)-1:0]   wb_pending
);

   localparam int IW = $clog2(NREQ);

   logic [IW-1:0]       r_rr_ptr;
   logic                r_we;
   logic [AW-1:0]       r_wreg;
   logic [DW-1:0]       r_wdata;

   logic [NREQ-1:0]     w_req;
   logic [NREQ-1:0]     w_grant;
   logic [IW-1:0]       w_grant_idx;
   logic                w_grant_any;
   logic [AW-1:0]       w_addr;
   logic [DW-1:0]       w_data;
   logic [(2**AW)-1:0]  w_dec;

   // Gating the requests keeps ready low for the whole reset window.
   assign w_req = req_valid & {NREQ{reset_n}};

   rr_arbiter #(
      .N  (NREQ),
      .IW (IW)
   ) u_arb (
      .req       (w_req),
      .ptr       (r_rr_ptr),
      .grant     (w_grant),
      .grant_idx (w_grant_idx)
   );

   assign w_grant_any = |w_grant;
   assign req_ready   = w_grant;

   always_comb begin
      w_addr = '0;
      w_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_addr = w_addr | (req_addr[i*AW +: AW] & {AW{w_grant[i]}});
         w_data = w_data | (req_data[i*DW +: DW] & {DW{w_grant[i]}});
      end
   end

   // Writes to r0 still consume the requester but never raise the enable.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr <= IW'(NREQ - 1);
         r_we     <= 1'b0;
         r_wreg   <= '0;
         r_wdata  <= '0;
      end else begin
         r_we <= w_grant_any && (w_addr != '0);
         if (w_grant_any) begin
            r_rr_ptr <= w_grant_idx;
            r_wreg   <= w_addr;
            r_wdata  <= w_data;
         end
      end
   end

   assign ctrl_writeEnable = r_we;
   assign ctrl_writeReg    = r_wreg;
   assign data_writeReg    = r_wdata;

   generate
      if (AW == 5) begin : g_dec5
         decoder_5_to_32bits u_dec (
            .i_sel    (r_wreg),
            .o_onehot (w_dec)
         );
      end else begin : g_dec_generic
         assign w_dec = {{((2**AW)-1){1'b0}}, 1'b1} << r_wreg;
      end
   endgenerate

   assign wb_pending = w_dec & {(2**AW){r_we}};

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_regfile_wb_arbiter                                       |
// | Scoreboard bench with a round-robin reference model.                 |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int NR   = 32;

   logic                clock = 1'b0;
   logic                reset_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*AW-1:0]  req_addr;
   logic [NREQ*DW-1:0]  req_data;
   logic [NREQ-1:0]     req_ready;
   logic                ctrl_writeEnable;
   logic [AW-1:0]       ctrl_writeReg;
   logic [DW-1:0]       data_writeReg;
   logic [NR-1:0]       wb_pending;

   regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .req_valid        (req_valid),
      .req_addr         (req_addr),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .wb_pending       (wb_pending)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit            we;
      bit            chk_rd;
      logic [AW-1:0] wreg;
      logic [DW-1:0] wdata;
      logic [NR-1:0] pend;
   } exp_t;

   exp_t            q[$];
   int              n_checks = 0;
   int              n_fail   = 0;
   bit              pend[NREQ];
   logic [AW-1:0]   m_addr[NREQ];
   logic [DW-1:0]   m_data[NREQ];
   int              waitc[NREQ];
   int              m_ptr;
   bit              hold_known;
   logic [AW-1:0]   last_reg;
   logic [DW-1:0]   last_data;
   logic [NREQ-1:0] last_ready;
   logic [DW-1:0]   shadow[NR];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: first valid requester found walking upward from last grant + 1.
   function automatic int model_grant(input int last, input logic [NREQ-1:0] v);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic step();
      int              g;
      logic [NREQ-1:0] v;
      logic [NR-1:0]   one;
      exp_t            e;
      @(negedge clock);
      for (int i = 0; i < NREQ; i++) begin
         v[i]                  = pend[i];
         req_valid[i]          = pend[i];
         req_addr[i*AW +: AW]  = m_addr[i];
         req_data[i*DW +: DW]  = m_data[i];
      end
      #1;
      g = model_grant(m_ptr, v);
      check("ready", {61'd0, req_ready}, (g >= 0) ? (64'd1 << g) : 64'd0);
      last_ready = req_ready;
      for (int i = 0; i < NREQ; i++) begin
         if (v[i] && !req_ready[i]) begin
            waitc[i]++;
            check($sformatf("fairness_req%0d", i), {63'd0, waitc[i] <= NREQ - 1}, 64'd1);
         end else begin
            waitc[i] = 0;
         end
      end
      one = 1;
      if (g >= 0 && m_addr[g] != 0) begin
         e = '{we: 1'b1, chk_rd: 1'b1, wreg: m_addr[g], wdata: m_data[g], pend: one << m_addr[g]};
         hold_known = 1'b1;
         last_reg   = m_addr[g];
         last_data  = m_data[g];
      end else begin
         e = '{we: 1'b0, chk_rd: (g < 0) && hold_known, wreg: last_reg, wdata: last_data, pend: '0};
         if (g >= 0) hold_known = 1'b0;
      end
      q.push_back(e);
      if (g >= 0) begin
         pend[g] = 1'b0;
         m_ptr   = g;
      end
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pend[i]   = 1'b1;
      m_addr[i] = a;
      m_data[i] = d;
   endtask

   task automatic model_reset();
      q.delete();
      m_ptr      = NREQ - 1;
      hold_known = 1'b0;
      for (int i = 0; i < NREQ; i++) waitc[i] = 0;
   endtask

   // Monitor: pops one expectation per cycle in which a step presented inputs.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (reset_n === 1'b1) begin
            if (ctrl_writeEnable) shadow[ctrl_writeReg] = data_writeReg;
            if (q.size() > 0) begin
               e = q.pop_front();
               check("writeEnable", {63'd0, ctrl_writeEnable}, {63'd0, e.we});
               if (e.chk_rd) begin
                  check("writeReg", {59'd0, ctrl_writeReg}, {59'd0, e.wreg});
                  check("writeData", {32'd0, data_writeReg}, {32'd0, e.wdata});
               end
               check("wb_pending", {32'd0, wb_pending}, {32'd0, e.pend});
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NREQ-1:0] seq[6];
      seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      reset_n   = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
      end
      last_reg  = '0;
      last_data = '0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("rst_we",   {63'd0, ctrl_writeEnable}, 64'd0);
      check("rst_reg",  {59'd0, ctrl_writeReg}, 64'd0);
      check("rst_data", {32'd0, data_writeReg}, 64'd0);
      check("rst_pend", {32'd0, wb_pending}, 64'd0);
      check("rst_ready", {61'd0, req_ready}, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // All three held valid: strict rotation starting at req0.
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < NREQ; i++) if (!pend[i]) set_req(i, AW'(10 + i), $urandom);
         step();
         check($sformatf("rotation_%0d", k), {61'd0, last_ready}, {61'd0, seq[k]});
      end
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      step();

      set_req(0, 5'd5, 32'hDEADBEEF);
      step();
      check("t1_ready", {61'd0, last_ready}, 64'd1);
      step();

      set_req(1, 5'd0, 32'h1234);
      step();
      check("t3_ready", {61'd0, last_ready}, 64'd2);
      step();

      set_req(0, 5'd3, 32'h33);
      step();
      set_req(0, 5'd7, 32'hA);
      set_req(2, 5'd7, 32'hB);
      step();
      check("t4_first", {61'd0, last_ready}, 64'd4);
      step();
      check("t4_second", {61'd0, last_ready}, 64'd1);
      step();
      step();
      check("t4_r7", {32'd0, shadow[7]}, 64'hA);

      set_req(0, 5'd9, 32'h99);
      step();
      step();
      step();
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(20 + i), $urandom);
      step();
      check("t6_ptr_hold", {61'd0, last_ready}, 64'd2);

      // Reset mid-burst while a write sits in the output stage.
      step();
      @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      check("t5_we",    {63'd0, ctrl_writeEnable}, 64'd0);
      check("t5_reg",   {59'd0, ctrl_writeReg}, 64'd0);
      check("t5_data",  {32'd0, data_writeReg}, 64'd0);
      check("t5_pend",  {32'd0, wb_pending}, 64'd0);
      check("t5_ready", {61'd0, req_ready}, 64'd0);
      req_valid = '0;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(1 + i), $urandom);
      step();
      check("t5_after", {61'd0, last_ready}, 64'd1);

      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++)
            if (!pend[i] && $urandom_range(0, 1) == 1)
               set_req(i, AW'($urandom_range(0, NR - 1)), $urandom);
         step();
      end
      for (int n = 0; n < 6; n++) step();
      @(posedge clock);
      #2;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
